// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Round-robin arbiter and sequencer that shares one external combinational
// ALU between NREQ requesters. In IDLE the first pending request at or after
// the round-robin pointer is granted (combinational one-hot req_ready). The
// winner's op code and operands are latched, driven to the ALU for one EXEC
// cycle, and the ALU result/flags are registered and returned with a one-cycle
// resp_valid pulse to the winner.
//
// Parameters:
//   N     - datapath width (matches the ALU width)
//   NREQ  - number of requesters (2..8)
//
// Ports:
//   clk            in   rising-edge clock
//   reset_n        in   asynchronous active-low reset
//   req_valid      in   [NREQ]     request pending per requester
//   req_op         in   [4*NREQ]   op code of requester i at [4i+3:4i]
//   req_a, req_b   in   [N*NREQ]   operands of requester i at [N*i+N-1:N*i]
//   req_ready      out  [NREQ]     one-hot grant (IDLE only)
//   alu_op_code    out  [4]        latched op code to the ALU
//   alu_operand1/2 out  [N]        latched operands to the ALU
//   alu_result     in   [N]        ALU result
//   alu_zero       in              ALU zero flag
//   alu_overflow   in              ALU overflow flag
//   resp_valid     out  [NREQ]     one-hot, one-cycle completion pulse
//   resp_result    out  [N]        registered result, held until next completion
//   resp_zero      out             registered zero flag
//   resp_overflow  out             registered overflow flag
//   resp_err       out             illegal-op flag (0 unless the option below)
//   busy           out             high while in EXEC
//
// Build option:
//   ALU_ARB_ILLEGAL_OP_EN - when defined, op codes 10..15 are flagged at
//   acceptance; the ALU sees op 0 and the response is forced to
//   result=0, zero=1, overflow=0, err=1. When undefined every op code is
//   passed to the ALU unchanged and resp_err stays 0.
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int N    = 32,
    parameter int NREQ = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [4*NREQ-1:0]   req_op,
    input  logic [N*NREQ-1:0]   req_a,
    input  logic [N*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic [3:0]          alu_op_code,
    output logic [N-1:0]        alu_operand1,
    output logic [N-1:0]        alu_operand2,
    input  logic [N-1:0]        alu_result,
    input  logic                alu_zero,
    input  logic                alu_overflow,
    output logic [NREQ-1:0]     resp_valid,
    output logic [N-1:0]        resp_result,
    output logic                resp_zero,
    output logic                resp_overflow,
    output logic                resp_err,
    output logic                busy
);

    // Width of the requester index / round-robin pointer.
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // FSM encoding.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EXEC = 1'b1;

`ifdef ALU_ARB_ILLEGAL_OP_EN
    localparam logic ILLEGAL_OP_EN = 1'b1;
`else
    localparam logic ILLEGAL_OP_EN = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // One-hot decode of a requester index.
    function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
        logic [NREQ-1:0] v;
        v = '0;
        for (int i = 0; i < NREQ; i++) begin
            v[i] = (PW'(i) == idx);
        end
        return v;
    endfunction

    // Round-robin successor of a requester index, wrapping modulo NREQ
    // (NREQ need not be a power of two).
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] idx);
        logic [PW-1:0] n;
        if (idx == PW'(NREQ - 1)) begin
            n = '0;
        end else begin
            n = idx + PW'(1);
        end
        return n;
    endfunction

    // Op codes above 9 are illegal only when the checking option is built in;
    // otherwise this folds to constant 0 and the flag logic disappears.
    function automatic logic is_illegal_op(input logic [3:0] op);
        return ILLEGAL_OP_EN && (op > 4'd9);
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [0:0]      state_q,         state_d;
    logic [PW-1:0]   ptr_q,           ptr_d;
    logic [PW-1:0]   winner_q,        winner_d;
    logic [3:0]      op_q,            op_d;
    logic [N-1:0]    a_q,             a_d;
    logic [N-1:0]    b_q,             b_d;
    logic            illegal_q,       illegal_d;
    logic [NREQ-1:0] resp_valid_q,    resp_valid_d;
    logic [N-1:0]    resp_result_q,   resp_result_d;
    logic            resp_zero_q,     resp_zero_d;
    logic            resp_overflow_q, resp_overflow_d;
    logic            resp_err_q,      resp_err_d;

    // Arbitration intermediates.
    logic [PW-1:0]   cand_s;
    logic            grant_found_s;
    logic [PW-1:0]   grant_idx_s;
    logic [3:0]      sel_op_s;
    logic [N-1:0]    sel_a_s;
    logic [N-1:0]    sel_b_s;
    logic            sel_illegal_s;
    logic            accept_s;

    // Round-robin search: first asserted req_valid starting at ptr_q, wrapping.
    always_comb begin
        cand_s        = '0;
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand_s = PW'((int'(ptr_q) + i) % NREQ);
            if (!grant_found_s && req_valid[cand_s]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Operand/op mux for the candidate winner (constant slice per requester).
    always_comb begin
        sel_op_s = 4'd0;
        sel_a_s  = '0;
        sel_b_s  = '0;
        for (int i = 0; i < NREQ; i++) begin
            sel_op_s = (PW'(i) == grant_idx_s) ? req_op[4*i +: 4] : sel_op_s;
            sel_a_s  = (PW'(i) == grant_idx_s) ? req_a[N*i +: N]  : sel_a_s;
            sel_b_s  = (PW'(i) == grant_idx_s) ? req_b[N*i +: N]  : sel_b_s;
        end
        sel_illegal_s = is_illegal_op(sel_op_s);
    end

    // Grant is offered only in IDLE; acceptance is grant qualified by valid,
    // which the search already guarantees for the chosen index.
    always_comb begin
        if ((state_q == ST_IDLE) && grant_found_s) begin
            req_ready = onehot(grant_idx_s);
            accept_s  = 1'b1;
        end else begin
            req_ready = '0;
            accept_s  = 1'b0;
        end
    end

    // FSM next-state, request latching and response capture.
    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        winner_d        = winner_q;
        op_d            = op_q;
        a_d             = a_q;
        b_d             = b_q;
        illegal_d       = illegal_q;
        resp_valid_d    = '0;
        resp_result_d   = resp_result_q;
        resp_zero_d     = resp_zero_q;
        resp_overflow_d = resp_overflow_q;
        resp_err_d      = resp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    // An illegal op is presented to the ALU as op 0 so the
                    // ALU never sees an undefined code.
                    op_d      = sel_illegal_s ? 4'd0 : sel_op_s;
                    a_d       = sel_a_s;
                    b_d       = sel_b_s;
                    illegal_d = sel_illegal_s;
                    winner_d  = grant_idx_s;
                    ptr_d     = next_ptr(grant_idx_s);
                    state_d   = ST_EXEC;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_EXEC: begin
                resp_valid_d = onehot(winner_q);
                if (illegal_q) begin
                    resp_result_d   = '0;
                    resp_zero_d     = 1'b1;
                    resp_overflow_d = 1'b0;
                    resp_err_d      = 1'b1;
                end else begin
                    resp_result_d   = alu_result;
                    resp_zero_d     = alu_zero;
                    resp_overflow_d = alu_overflow;
                    resp_err_d      = 1'b0;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            ptr_q           <= '0;
            winner_q        <= '0;
            op_q            <= 4'd0;
            a_q             <= '0;
            b_q             <= '0;
            illegal_q       <= 1'b0;
            resp_valid_q    <= '0;
            resp_result_q   <= '0;
            resp_zero_q     <= 1'b0;
            resp_overflow_q <= 1'b0;
            resp_err_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            winner_q        <= winner_d;
            op_q            <= op_d;
            a_q             <= a_d;
            b_q             <= b_d;
            illegal_q       <= illegal_d;
            resp_valid_q    <= resp_valid_d;
            resp_result_q   <= resp_result_d;
            resp_zero_q     <= resp_zero_d;
            resp_overflow_q <= resp_overflow_d;
            resp_err_q      <= resp_err_d;
        end
    end

    // The ALU is always driven from the latch registers, so it stays stable
    // in IDLE.
    assign alu_op_code   = op_q;
    assign alu_operand1  = a_q;
    assign alu_operand2  = b_q;

    assign resp_valid    = resp_valid_q;
    assign resp_result   = resp_result_q;
    assign resp_zero     = resp_zero_q;
    assign resp_overflow = resp_overflow_q;
    assign resp_err      = resp_err_q;
    assign busy          = (state_q == ST_EXEC);

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed testbench for alu_arbiter (N=32, NREQ=4). A small behavioural ALU
// is attached to the alu_* ports. Expected responses are pushed to a
// scoreboard queue when a request is driven and popped by a monitor whenever
// resp_valid pulses. Honors ALU_ARB_ILLEGAL_OP_EN for the illegal-op case.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int N    = 32;
    localparam int NREQ = 4;

    logic                clk;
    logic                reset_n;
    logic [NREQ-1:0]     req_valid;
    logic [4*NREQ-1:0]   req_op;
    logic [N*NREQ-1:0]   req_a;
    logic [N*NREQ-1:0]   req_b;
    logic [NREQ-1:0]     req_ready;
    logic [3:0]          alu_op_code;
    logic [N-1:0]        alu_operand1;
    logic [N-1:0]        alu_operand2;
    logic [N-1:0]        alu_result;
    logic                alu_zero;
    logic                alu_overflow;
    logic [NREQ-1:0]     resp_valid;
    logic [N-1:0]        resp_result;
    logic                resp_zero;
    logic                resp_overflow;
    logic                resp_err;
    logic                busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NREQ-1:0] mask;
        logic [N-1:0]    res;
        logic            z;
        logic            o;
        logic            err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic [N:0] alu_r;

    alu_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_ready    (req_ready),
        .alu_op_code  (alu_op_code),
        .alu_operand1 (alu_operand1),
        .alu_operand2 (alu_operand2),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .resp_valid   (resp_valid),
        .resp_result  (resp_result),
        .resp_zero    (resp_zero),
        .resp_overflow(resp_overflow),
        .resp_err     (resp_err),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: returns {overflow, result}.
    function automatic logic [N:0] alu_f(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] r;
        logic         o;
        o = 1'b0;
        case (op)
            4'd0: r = a | b;
            4'd1: r = a ^ b;
            4'd3: begin
                r = a + b;
                o = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
            end
            4'd4: begin
                r = a - b;
                o = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
            end
            4'd5: r = a & b;
            default: r = a ^ b ^ {28'd0, op};
        endcase
        return {o, r};
    endfunction

    always_comb begin
        alu_r = alu_f(alu_op_code, alu_operand1, alu_operand2);
    end
    assign alu_result   = alu_r[N-1:0];
    assign alu_overflow = alu_r[N];
    assign alu_zero     = (alu_r[N-1:0] == 32'd0);

    function automatic logic [NREQ-1:0] oh(input int i);
        logic [NREQ-1:0] v;
        v = 4'b0001 << i;
        return v;
    endfunction

    function automatic logic illegal_f(input logic [3:0] op);
        logic ill;
        ill = 1'b0;
`ifdef ALU_ARB_ILLEGAL_OP_EN
        ill = (op > 4'd9);
`endif
        return ill;
    endfunction

    function automatic exp_t expect_of(input int i, input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t       e;
        logic [N:0] r;
        e.mask = oh(i);
        if (illegal_f(op)) begin
            e.res = 32'd0; e.z = 1'b1; e.o = 1'b0; e.err = 1'b1;
        end else begin
            r = alu_f(op, a, b);
            e.res = r[N-1:0]; e.z = (r[N-1:0] == 32'd0); e.o = r[N]; e.err = 1'b0;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        req_valid[i]     = v;
        req_op[4*i +: 4] = op;
        req_a[N*i +: N]  = a;
        req_b[N*i +: N]  = b;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_req_ready"},  64'(req_ready),     64'd0);
        check({pfx, "_resp_valid"}, 64'(resp_valid),    64'd0);
        check({pfx, "_busy"},       64'(busy),          64'd0);
        check({pfx, "_resp_res"},   64'(resp_result),   64'd0);
        check({pfx, "_resp_zero"},  64'(resp_zero),     64'd0);
        check({pfx, "_resp_ovf"},   64'(resp_overflow), 64'd0);
        check({pfx, "_resp_err"},   64'(resp_err),      64'd0);
        check({pfx, "_alu_op"},     64'(alu_op_code),   64'd0);
        check({pfx, "_alu_a"},      64'(alu_operand1),  64'd0);
        check({pfx, "_alu_b"},      64'(alu_operand2),  64'd0);
    endtask

    // One isolated request: grant, EXEC contents and response timing.
    task automatic do_single(input int i, input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        logic [3:0] exp_op;
        exp_op = illegal_f(op) ? 4'd0 : op;
        @(posedge clk); #1;
        set_req(i, 1'b1, op, a, b);
        sb_q.push_back(expect_of(i, op, a, b));
        @(negedge clk);
        check("single_grant", 64'(req_ready), 64'(oh(i)));
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        @(negedge clk);
        check("single_busy",   64'(busy),         64'd1);
        check("single_noready",64'(req_ready),    64'd0);
        check("single_alu_op", 64'(alu_op_code),  64'(exp_op));
        check("single_alu_a",  64'(alu_operand1), 64'(a));
        check("single_alu_b",  64'(alu_operand2), 64'(b));
        @(posedge clk);
        @(negedge clk);
        check("single_resp_pulse", 64'(resp_valid), 64'(oh(i)));
        check("single_idle",       64'(busy),       64'd0);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        check("sb_drain", 64'(sb_q.size()), 64'd0);
    endtask

    // Monitor: every response pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (resp_valid !== 4'b0000) begin
            if (sb_q.size() == 0) begin
                check("resp_unexpected", 64'(resp_valid), 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("resp_mask", 64'(resp_valid),    64'(mon_e.mask));
                check("resp_res",  64'(resp_result),   64'(mon_e.res));
                check("resp_zero", 64'(resp_zero),     64'(mon_e.z));
                check("resp_ovf",  64'(resp_overflow), 64'(mon_e.o));
                check("resp_err",  64'(resp_err),      64'(mon_e.err));
            end
        end
    end

    initial begin
        int waited;
        reset_n   = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Single request: requester 2, op 3 (add), 5 + 7.
        do_single(2, 4'd3, 32'd5, 32'd7);
        check("add_result", 64'(resp_result), 64'd12);
        check("add_zero",   64'(resp_zero),   64'd0);

        // Zero flag: requester 0 (wraps from ptr 3), op 4 (sub), a == b.
        do_single(0, 4'd4, 32'h1234, 32'h1234);
        check("sub_result", 64'(resp_result), 64'd0);
        check("sub_zero",   64'(resp_zero),   64'd1);

        // Signed overflow on add: requester 1.
        do_single(1, 4'd3, 32'h7FFF_FFFF, 32'h0000_0001);
        check("ovf_flag",   64'(resp_overflow), 64'd1);
        check("ovf_result", 64'(resp_result),   64'h8000_0000);

        // Requester 3 (xor) moves the pointer back to 0.
        do_single(3, 4'd1, 32'hF0F0_0000, 32'h0F0F_1111);

        // Fairness: all four hold valid with op 5 and distinct operands.
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 1'b1, 4'd5, 32'h0F0F_0F0F ^ (32'(i) * 32'h1111_1111), 32'hFFFF_0000 + 32'(i));
        end
        for (int g = 0; g < 8; g++) begin
            sb_q.push_back(expect_of(g % NREQ, 4'd5,
                32'h0F0F_0F0F ^ (32'(g % NREQ) * 32'h1111_1111), 32'hFFFF_0000 + 32'(g % NREQ)));
        end
        for (int g = 0; g < 8; g++) begin
            waited = 0;
            @(negedge clk);
            while (req_ready == 4'b0000 && waited < 8) begin
                @(negedge clk);
                waited++;
            end
            check("fair_grant", 64'(req_ready), 64'(oh(g % NREQ)));
            check("fair_gap",   64'(waited),    (g == 0) ? 64'd0 : 64'd1);
        end
        @(posedge clk); #1;
        req_valid = '0;
        wait_drain();

        // Back-to-back: requester 1 alone, re-requests during its pulse.
        @(posedge clk); #1;
        set_req(1, 1'b1, 4'd3, 32'd100, 32'd23);
        sb_q.push_back(expect_of(1, 4'd3, 32'd100, 32'd23));
        @(negedge clk);
        check("b2b_grant1", 64'(req_ready), 64'b0010);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        set_req(1, 1'b1, 4'd4, 32'd50, 32'd8);
        sb_q.push_back(expect_of(1, 4'd4, 32'd50, 32'd8));
        @(negedge clk);
        check("b2b_pulse1", 64'(resp_valid), 64'b0010);
        check("b2b_regrant",64'(req_ready),  64'b0010);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        check("b2b_hold_valid", 64'(resp_valid),  64'd0);
        check("b2b_hold_res",   64'(resp_result), 64'd123);
        @(negedge clk);
        check("b2b_pulse2",     64'(resp_valid),  64'b0010);
        check("b2b_res2",       64'(resp_result), 64'd42);
        @(negedge clk);
        check("b2b_hold2",      64'(resp_result), 64'd42);
        wait_drain();

        // Reset during EXEC of op 0 (a=1, b=4): everything clears, no response.
        @(posedge clk); #1;
        set_req(0, 1'b1, 4'd0, 32'd1, 32'd4);
        @(negedge clk);
        check("rst_grant", 64'(req_ready), 64'b0001);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check_all_zero("rst_exec");
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_no_resp", 64'(resp_valid), 64'd0);
        end
        // Pointer back at 0: with 0 and 3 both pending, 0 wins.
        @(posedge clk); #1;
        set_req(0, 1'b1, 4'd5, 32'hFF00_FF00, 32'h0FF0_0FF0);
        set_req(3, 1'b1, 4'd1, 32'd9, 32'd9);
        sb_q.push_back(expect_of(0, 4'd5, 32'hFF00_FF00, 32'h0FF0_0FF0));
        @(negedge clk);
        check("rst_ptr0", 64'(req_ready), 64'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        wait_drain();

        // Illegal op 12 from requester 2.
        do_single(2, 4'd12, 32'd6, 32'd9);
`ifdef ALU_ARB_ILLEGAL_OP_EN
        check("ill_err",    64'(resp_err),    64'd1);
        check("ill_result", 64'(resp_result), 64'd0);
        check("ill_zero",   64'(resp_zero),   64'd1);
`else
        check("ill_err",    64'(resp_err),    64'd0);
        check("ill_result", 64'(resp_result), 64'd3);
        check("ill_zero",   64'(resp_zero),   64'd0);
`endif
        wait_drain();

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
